// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - pixel-side bundle between the VGA timing core and pattern logic
interface vga_sync_gen_if;
  logic       ena;
  logic [5:0] rgb_in;
  logic       pix_en;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       active;
  logic       frame_start;
  logic [7:0] uo_out;

  // master: pattern/sprite logic; slave: the timing generator
  modport master (
    output ena, rgb_in,
    input  pix_en, hpos, vpos, active, frame_start, uo_out
  );

  modport slave (
    input  ena, rgb_in,
    output pix_en, hpos, vpos, active, frame_start, uo_out
  );
endinterface

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 VGA timing with TinyVGA-ordered registered output bus
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_sync_gen_if.slave  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0]       H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0]      H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0]      V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0]      H_SYNC_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]      H_SYNC_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]      V_SYNC_ON  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]      V_SYNC_OFF = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [7:0]       UO_IDLE    = 8'h88;

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       hpos_q;
  logic [9:0]       vpos_q;
  logic [7:0]       uo_q;
  logic             frame_start_q;
  logic             pix_en;
  logic             active;
  logic             hs_n;
  logic             vs_n;
  logic [5:0]       rgb_m;

  always @(posedge clk) begin : p_limits
    assert (H_TOTAL <= 1024 && V_TOTAL <= 1024)
      else $error("vga_sync_gen: timing totals exceed 10-bit counter range");
  end

  assign pix_en = vga.ena && (div_cnt == '0);
  assign active = ({1'b0, hpos_q} < H_ACT) && ({1'b0, vpos_q} < V_ACT);
  assign hs_n   = !(({1'b0, hpos_q} >= H_SYNC_ON) && ({1'b0, hpos_q} < H_SYNC_OFF));
  assign vs_n   = !(({1'b0, vpos_q} >= V_SYNC_ON) && ({1'b0, vpos_q} < V_SYNC_OFF));
  // colour is blanked outside the visible area regardless of rgb_in
  assign rgb_m  = vga.rgb_in & {6{active}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt       <= '0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      uo_q          <= UO_IDLE;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (!vga.ena) begin
        uo_q <= UO_IDLE;
      end else begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        if (pix_en) begin
          // TinyVGA pin order: {hs, B0, G0, R0, vs, B1, G1, R1}
          uo_q <= {hs_n, rgb_m[0], rgb_m[2], rgb_m[4], vs_n, rgb_m[1], rgb_m[3], rgb_m[5]};
          if (hpos_q == H_LAST) begin
            hpos_q        <= '0;
            vpos_q        <= (vpos_q == V_LAST) ? '0 : vpos_q + 1'b1;
            frame_start_q <= (vpos_q == V_LAST);
          end else begin
            hpos_q <= hpos_q + 1'b1;
          end
        end
      end
    end
  end

  assign vga.pix_en      = pix_en;
  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.active      = active;
  assign vga.frame_start = frame_start_q;
  assign vga.uo_out      = uo_q;

endmodule
